// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small write FIFO in front of the shifter.
// Bytes are popped straight into the shifter, so back-to-back frames leave no idle gap.
module uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   DEPTH_FULL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         state;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic bit_done;

  // Handshake: a byte transfers on the rising edge where wr_valid && wr_ready;
  // wr_ready depends only on the FIFO fill level, never on wr_valid, and a
  // pop in the same cycle does not free a slot until the following cycle.
  assign full     = (fifo_count == DEPTH_FULL);
  assign empty    = (fifo_count == '0);
  assign wr_ready = !full;
  assign push     = wr_valid && wr_ready;
  assign bit_done = (baud_cnt == BAUD_LAST);
  assign pop      = !empty && ((state == IDLE) || ((state == STOP) && bit_done));
  assign busy     = (state != IDLE) || !empty;

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (resetn && push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      txd        <= 1'b1;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            txd      <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= START;
          end
        end

        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            txd      <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              // txd takes the next bit directly so it stays a clean register output
              shift   <= {1'b0, shift[7:1]};
              txd     <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shift   <= mem[rd_ptr];
              txd     <= 1'b0;
              bit_idx <= '0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          txd   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-timeline reference model with per-cycle compare,
// serial decoder against an expected byte queue, and directed scenarios.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_count;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // reference model: bytes waiting, plus the frame currently on the line
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  bit         model_valid = 1'b0;
  bit         in_flight   = 1'b0;
  int         elapsed     = 0;
  logic [7:0] cur         = 8'h00;
  bit         dec_abort   = 1'b0;
  bit         acc;

  // serial decoder state
  bit         dec_on  = 1'b0;
  int         dcnt    = 0;
  logic [7:0] db      = 8'h00;
  int         n_decoded = 0;
  int         start_times[$];

  logic [9:0] f55 = 10'b1010101010;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // model step on each rising edge, from the inputs the DUT sees
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (resetn !== 1'b1) begin
        mq.delete();
        exp_q.delete();
        in_flight   = 1'b0;
        elapsed     = 0;
        model_valid = 1'b1;
        dec_abort   = 1'b1;
      end else if (model_valid) begin
        acc = wr_valid && (mq.size() < DEPTH);
        if (in_flight) begin
          elapsed++;
          if (elapsed == 10 * CPB) in_flight = 1'b0;
        end
        if (!in_flight && mq.size() > 0) begin
          cur       = mq.pop_front();
          in_flight = 1'b1;
          elapsed   = 0;
        end
        if (acc) begin
          mq.push_back(wr_data);
          exp_q.push_back(wr_data);
        end
      end
    end
  end

  // per-cycle compare of every output against the model
  initial begin
    logic [9:0] fr;
    logic       e_txd;
    forever begin
      @(negedge clk);
      if (model_valid) begin
        fr    = {1'b1, cur, 1'b0};
        e_txd = in_flight ? fr[elapsed / CPB] : 1'b1;
        chk("model_txd", txd, e_txd);
        chk("model_busy", busy, in_flight || (mq.size() != 0));
        chk("model_fifo_count", fifo_count, mq.size());
        chk("model_wr_ready", wr_ready, mq.size() < DEPTH);
      end
    end
  end

  // serial decoder: mid-bit sampling, bytes checked against exp_q
  initial begin
    forever begin
      @(negedge clk);
      if (dec_abort || resetn !== 1'b1) begin
        dec_abort = 1'b0;
        dec_on    = 1'b0;
      end else if (!dec_on) begin
        if (txd === 1'b0) begin
          dec_on = 1'b1;
          dcnt   = 0;
          start_times.push_back(cyc);
        end
      end else begin
        dcnt++;
        if (dcnt == CPB / 2) begin
          chk("dec_start_bit", txd, 1'b0);
        end else if ((dcnt % CPB) == CPB / 2 && dcnt / CPB >= 1 && dcnt / CPB <= 8) begin
          db[dcnt / CPB - 1] = txd;
        end else if (dcnt == 9 * CPB + CPB / 2) begin
          chk("dec_stop_bit", txd, 1'b1);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL dec_byte at cycle %0d: got %0h, expected none queued", cyc, db);
          end else begin
            chk("dec_byte", db, exp_q.pop_front());
          end
          n_decoded++;
          dec_on = 1'b0;
        end
      end
    end
  end

  // called at a falling edge; returns at the falling edge after the accepting edge
  task automatic push(input logic [7:0] b);
    int n;
    n        = 0;
    wr_valid = 1'b1;
    wr_data  = b;
    while (wr_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL push_timeout at cycle %0d: got wr_ready=%0b, expected 1", cyc, wr_ready);
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", busy, 1'b0);
  endtask

  initial begin
    #900000;
    failures++;
    checks++;
    $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int s0;
    int d0;
    int d;
    int acc_t [1:6];
    int n;
    bit rdy_now;

    resetn   = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // idle after reset
    repeat (100) begin
      @(negedge clk);
      chk("idle_txd", txd, 1'b1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_wr_ready", wr_ready, 1'b1);
      chk("idle_fifo_count", fifo_count, 3'd0);
    end

    // single byte 0x55: txd=0 from edge k+1, busy falls at edge k+41
    push(8'h55);
    for (int j = 1; j <= 41; j++) begin
      @(negedge clk);
      chk("b55_txd", txd, (j <= 40) ? f55[(j - 1) / CPB] : 1'b1);
      if (j == 40) chk("b55_busy_last", busy, 1'b1);
      if (j == 41) chk("b55_busy_fall", busy, 1'b0);
    end
    repeat (5) @(negedge clk);

    // back-to-back frames: second start exactly 40 cycles after the first
    s0 = start_times.size();
    d0 = n_decoded;
    push(8'hA1);
    push(8'hA2);
    wait_idle(200);
    chk("b2b_starts", start_times.size() - s0, 2);
    if (start_times.size() - s0 == 2) chk("b2b_gap", start_times[s0 + 1] - start_times[s0], 40);
    chk("b2b_decoded", n_decoded - d0, 2);
    repeat (3) @(negedge clk);

    // backpressure: 0x01..0x06 with wr_valid held high
    d0       = n_decoded;
    d        = 1;
    n        = 0;
    wr_valid = 1'b1;
    wr_data  = 8'h01;
    while (d <= 6 && n < 500) begin
      rdy_now = wr_ready;
      @(negedge clk);
      n++;
      if (rdy_now) begin
        acc_t[d] = cyc;
        if (d == 5) begin
          chk("bp_full_count", fifo_count, 3'd4);
          chk("bp_full_ready", wr_ready, 1'b0);
        end
        d++;
        if (d <= 6) wr_data = 8'(d);
        else wr_valid = 1'b0;
      end
    end
    wr_valid = 1'b0;
    chk("bp_all_accepted", d, 7);
    if (d == 7) begin
      chk("bp_fifth_offset", acc_t[5] - acc_t[1], 4);
      chk("bp_sixth_offset", acc_t[6] - acc_t[1], 42);
    end
    wait_idle(400);
    chk("bp_decoded", n_decoded - d0, 6);
    repeat (3) @(negedge clk);

    // reset at cycle 15 of the first frame, with a write attempted during reset
    push(8'hFF);
    push(8'h00);
    repeat (14) @(negedge clk);
    resetn   = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    @(negedge clk);
    resetn   = 1'b1;
    wr_valid = 1'b0;
    chk("rst_txd", txd, 1'b1);
    chk("rst_fifo_count", fifo_count, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    s0 = start_times.size();
    repeat (100) begin
      @(negedge clk);
      chk("rst_quiet_txd", txd, 1'b1);
    end
    chk("rst_no_start", start_times.size() - s0, 0);
    chk("rst_no_pending", exp_q.size(), 0);

    // random bytes with random gaps
    d0 = n_decoded;
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 60)) @(negedge clk);
      push(8'($urandom_range(0, 255)));
    end
    wait_idle(1000);
    chk("rand_decoded", n_decoded - d0, 256);
    chk("rand_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
